multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multicycle successor to the single-cycle ARM controller: one FSM sequences each instruction
//  over 3-5+ cycles on a shared memory/ALU datapath. Holds the NZCV flag register and
//  condition logic. Adds a configurable memory-read wait, ALU-control widening and optional CMP.
//  Sits between the instruction register and the multicycle datapath.
// PARAMETERS
//  ALUCTRL_W  2  ALUControl width (>=2); bits above [1:0] driven 0
//  MEM_LAT    1  cycles spent in MEMREAD before MEMWB (>=1)
//  STATE_W    4  state register width (>=4)
// PORTS
//  CLK         in   1          rising-edge clock
//  Reset       in   1          synchronous, active-high
//  Cond        in   4          Instr[31:28]
//  ALUFlags    in   4          {N,Z,C,V} from ALU, same cycle
//  Op          in   2          Instr[27:26]
//  Funct       in   6          Instr[25:20]
//  Rd          in   4          Instr[15:12]
//  PCWrite     out  1          load PC
//  AdrSrc      out  1          0=PC, 1=ALUOut as memory address
//  MemWrite    out  1          memory write strobe
//  IRWrite     out  1          load instruction register
//  RegWrite    out  1          register file write
//  ResultSrc   out  2          00=ALUOut 01=Data 10=ALUResult
//  ALUSrcA     out  1          0=RD1, 1=PC
//  ALUSrcB     out  2          00=RD2 01=ExtImm 10=const 4
//  ImmSrc      out  2          Op (00 dp-imm8, 01 mem-imm12, 10 branch-imm24)
//  RegSrc      out  2          {Op==10, Op==01}
//  ALUControl  out  ALUCTRL_W  00 ADD, 01 SUB, 10 AND, 11 ORR
//  State       out  STATE_W    current FSM state (debug)
// BEHAVIOUR
//  Reset (sync): State=FETCH, flags=0000, wait counter=0. Outputs follow from FETCH.
//  States/transitions (Moore; outputs not listed are 0, ALUControl=ADD):
//   FETCH    IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1     -> DECODE
//   DECODE   ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8). Op=01 -> MEMADR;
//            Op=00 -> Funct[5] ? EXECUTEI : EXECUTER; Op=10 -> BRANCH; Op=11 -> FETCH
//   MEMADR   ALUSrcB=01                       -> Funct[0] ? MEMREAD : MEMWRITE
//   MEMREAD  AdrSrc=1; held MEM_LAT cycles by counter, then -> MEMWB
//   MEMWB    ResultSrc=01, RegW=1             -> FETCH
//   MEMWRITE AdrSrc=1, MemW=1                 -> FETCH
//   EXECUTER ALUSrcB=00, ALUOp=1              -> ALUWB (FETCH if CMP)
//   EXECUTEI ALUSrcB=01, ALUOp=1              -> ALUWB (FETCH if CMP)
//   ALUWB    ResultSrc=00, RegW=1             -> FETCH
//   BRANCH   ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH
//  ALU decode when ALUOp=1, cmd=Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; other cmd
//   -> ADD, no flag write. FlagW[1]=Funct[0]; FlagW[0]=Funct[0]&(ADD|SUB).
//  CondEx: combinational from Cond vs stored flags; EQ..LE per ARM, 1110 AL=1, 1111=0.
//  Flags: at clock edge ending EXECUTER/EXECUTEI, if CondEx: NZ<=ALUFlags[3:2] when FlagW[1],
//   CV<=ALUFlags[1:0] when FlagW[0]. Never updated in any other state.
//  RegWrite=RegW&CondEx; MemWrite=MemW&CondEx;
//   PCWrite=NextPC | ((Branch | (RegW & Rd==15)) & CondEx). Rd==15 writeback loads PC.
//  Failed condition: state sequence unchanged, strobes suppressed (fixed cycle count).
//  Reset asserted mid-instruction: next state FETCH, counter cleared, flags cleared.
// CONFIGURATION
//  CU_CMP_EN defined: cmd 1010 (CMP) -> ALUControl=SUB, FlagW=11 forced, EXECUTE* -> FETCH
//   (no ALUWB, RegWrite never asserted). Undefined: 1010 treated as unknown cmd (ADD, writes Rd).
// STRUCTURE
//  Package cu_pkg: state encodings, ALUControl codes, ResultSrc/ALUSrcB codes, cond codes.
//  Sub-module arm_cond_check (combinational Cond x flags -> CondEx).
// TESTING
//  ADD R1,R2,R3 (Op=00,Funct=001000,Cond=1110) -> FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 in ALUWB.
//  LDR, MEM_LAT=3 -> MEMREAD held 3 cycles, RegWrite=1 only in MEMWB, AdrSrc=1 in MEMREAD.
//  SUBS with ALUFlags=0100 then BEQ -> Z=1 stored; BRANCH cycle PCWrite=1. With Z=0 PCWrite=0.
//  STR with Cond=0000, Z=0 -> MemWrite=0 in MEMWRITE, 4 cycles, flags unchanged.
//  CMP (Funct=010101) with CU_CMP_EN -> EXECUTER->FETCH, flags updated, RegWrite never 1.
//  Reset pulse in MEMREAD -> State=FETCH next cycle, flags=0000, IRWrite=1.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath mux codes,
// ALU commands/controls, condition codes and the per-state control word.
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic       memw;
        logic       regw;
        logic       nextpc;
        logic       branch;
        logic       alusrca;
        logic       aluop;
        logic [1:0] resultsrc;
        logic [1:0] alusrcb;
    } ctrl_t;

    // Moore control word for each state; condition gating is applied later.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
                c.nextpc    = 1'b1;
            end
            S_DECODE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            S_MEMADR:   c.alusrcb = SRCB_EXTIMM;
            S_MEMREAD:  c.adrsrc  = 1'b1;
            S_MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regw      = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc = 1'b1;
                c.memw   = 1'b1;
            end
            S_EXECUTER: begin
                c.alusrcb = SRCB_RD2;
                c.aluop   = 1'b1;
            end
            S_EXECUTEI: begin
                c.alusrcb = SRCB_EXTIMM;
                c.aluop   = 1'b1;
            end
            S_ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regw      = 1'b1;
            end
            S_BRANCH: begin
                c.alusrcb   = SRCB_EXTIMM;
                c.resultsrc = RES_ALURESULT;
                c.branch    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition evaluation: Cond field against the stored {N,Z,C,V} flags.
module arm_cond_check
    import cu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = ~(n ^ v);
            COND_LT: condex = n ^ v;
            COND_GT: condex = ~z & ~(n ^ v);
            COND_LE: condex = z | (n ^ v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM controller: instruction-sequencing FSM, NZCV flag register and condition gating.
// Build option: define CU_CMP_EN to decode cmd 1010 as CMP (SUB, flags only, no writeback).
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int ALUCTRL_W = 2,
    parameter int MEM_LAT   = 1,
    parameter int STATE_W   = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [3:0]           Cond,
    input  logic [3:0]           ALUFlags,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [STATE_W-1:0]   State
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t           state_reg, state_next;
    ctrl_t            ctrl_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [3:0]       flags_reg;
    logic             condex;
    logic             wait_done;
    logic [3:0]       cmd;
    logic [1:0]       alu_sel;
    logic [1:0]       flagw;
    logic             is_cmp;
    logic             in_execute;

    arm_cond_check u_cond (
        .cond   (Cond),
        .flags  (flags_reg),
        .condex (condex)
    );

    assign cmd        = Funct[4:1];
    assign wait_done  = (wait_cnt_reg == CNT_W'(MEM_LAT - 1));
    assign in_execute = (state_reg == S_EXECUTER) || (state_reg == S_EXECUTEI);

    // Unknown commands fall back to ADD and never touch the flags.
    always_comb begin
        alu_sel = ALU_ADD;
        flagw   = 2'b00;
        is_cmp  = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_sel = ALU_ADD; flagw = {Funct[0], Funct[0]}; end
            CMD_SUB: begin alu_sel = ALU_SUB; flagw = {Funct[0], Funct[0]}; end
            CMD_AND: begin alu_sel = ALU_AND; flagw = {Funct[0], 1'b0}; end
            CMD_ORR: begin alu_sel = ALU_ORR; flagw = {Funct[0], 1'b0}; end
`ifdef CU_CMP_EN
            CMD_CMP: begin alu_sel = ALU_SUB; flagw = 2'b11; is_cmp = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = wait_done ? S_MEMWB : S_MEMREAD;
            S_EXECUTER,
            S_EXECUTEI: state_next = is_cmp ? S_FETCH : S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight from flops.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg    <= S_FETCH;
            ctrl_reg     <= state_ctrl(S_FETCH);
            wait_cnt_reg <= '0;
            flags_reg    <= 4'b0000;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= state_ctrl(state_next);
            if (state_reg == S_MEMREAD && !wait_done)
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            else
                wait_cnt_reg <= '0;
            if (in_execute && condex) begin
                if (flagw[1]) flags_reg[3:2] <= ALUFlags[3:2];
                if (flagw[0]) flags_reg[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign IRWrite   = ctrl_reg.irwrite;
    assign AdrSrc    = ctrl_reg.adrsrc;
    assign ALUSrcA   = ctrl_reg.alusrca;
    assign ALUSrcB   = ctrl_reg.alusrcb;
    assign ResultSrc = ctrl_reg.resultsrc;
    assign RegWrite  = ctrl_reg.regw & condex;
    assign MemWrite  = ctrl_reg.memw & condex;
    assign PCWrite   = ctrl_reg.nextpc
                     | ((ctrl_reg.branch | (ctrl_reg.regw & (Rd == 4'hF))) & condex);
    assign ImmSrc    = Op;
    assign RegSrc    = {Op == 2'b10, Op == 2'b01};
    assign State     = STATE_W'(state_reg);

    assign ALUControl[1:0] = ctrl_reg.aluop ? alu_sel : ALU_ADD;
    for (genvar gi = 2; gi < ALUCTRL_W; gi++) begin : g_aluctl_pad
        assign ALUControl[gi] = 1'b0;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus randomized
// instruction streams checked cycle-by-cycle against an instruction-level reference model.
module tb_multicycle_control_unit;
    import cu_pkg::*;

    localparam int ALUCTRL_W = 3;
    localparam int MEM_LAT   = 3;
    localparam int STATE_W   = 5;

    logic                 CLK = 1'b0;
    logic                 Reset;
    logic [3:0]           Cond;
    logic [3:0]           ALUFlags;
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic                 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]           ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [STATE_W-1:0]   State;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [3:0] mdl_flags = 4'b0000;

    always #5 CLK = ~CLK;

    multicycle_control_unit #(
        .ALUCTRL_W (ALUCTRL_W),
        .MEM_LAT   (MEM_LAT),
        .STATE_W   (STATE_W)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_cmp_model(input logic [5:0] funct);
`ifdef CU_CMP_EN
        return funct[4:1] == 4'b1010;
`else
        return 1'b0;
`endif
    endfunction

    // ALU operation an execute cycle must request: 0 ADD, 1 SUB, 2 AND, 3 ORR.
    function automatic logic [2:0] aluctl_model(input logic [5:0] funct);
        if (is_cmp_model(funct)) return 3'd1;
        case (funct[4:1])
            4'b0100: return 3'd0;
            4'b0010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    // Runs one instruction from FETCH back to the next FETCH, checking every cycle.
    // Entry/exit: one time unit after a rising edge, with the DUT in FETCH.
    task automatic run_instr(input string tag, input logic [3:0] cond, input logic [1:0] op,
                             input logic [5:0] funct, input logic [3:0] rd,
                             input logic fix_en, input logic [3:0] fix_flags,
                             output int ncyc, output int nregw, output int nmemw,
                             output int nmemrd, output logic last_pcw);
        state_t      seq[$];
        logic [16:0] exp_v, obs_v;
        logic        ce, pcw, adr, mw, irw, rw, sa;
        logic [1:0]  rs, sb;
        logic [2:0]  ac;
        logic [3:0]  al;
        logic        arith, known;
        Cond = cond; Op = op; Funct = funct; Rd = rd;
        seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (op)
            2'b01: begin
                seq.push_back(S_MEMADR);
                if (funct[0]) begin
                    for (int k = 0; k < MEM_LAT; k++) seq.push_back(S_MEMREAD);
                    seq.push_back(S_MEMWB);
                end else begin
                    seq.push_back(S_MEMWRITE);
                end
            end
            2'b00: begin
                seq.push_back(funct[5] ? S_EXECUTEI : S_EXECUTER);
                if (!is_cmp_model(funct)) seq.push_back(S_ALUWB);
            end
            2'b10: seq.push_back(S_BRANCH);
            default: ;
        endcase
        ncyc = 0; nregw = 0; nmemw = 0; nmemrd = 0; last_pcw = 1'b0;
        foreach (seq[i]) begin
            al = fix_en ? fix_flags : 4'($urandom);
            ALUFlags = al;
            @(negedge CLK);
            ce  = cond_model(cond, mdl_flags);
            pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; sa = 0; rs = 2'b00; sb = 2'b00; ac = 3'd0;
            case (seq[i])
                S_FETCH:    begin irw = 1; sa = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
                S_DECODE:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
                S_MEMADR:   sb = 2'b01;
                S_MEMREAD:  adr = 1;
                S_MEMWB:    begin rs = 2'b01; rw = ce; pcw = ce && (rd == 4'd15); end
                S_MEMWRITE: begin adr = 1; mw = ce; end
                S_EXECUTER: begin sb = 2'b00; ac = aluctl_model(funct); end
                S_EXECUTEI: begin sb = 2'b01; ac = aluctl_model(funct); end
                S_ALUWB:    begin rs = 2'b00; rw = ce; pcw = ce && (rd == 4'd15); end
                S_BRANCH:   begin sb = 2'b01; rs = 2'b10; pcw = ce; end
                default: ;
            endcase
            exp_v = {pcw, adr, mw, irw, rw, rs, sa, sb, op, op == 2'b10, op == 2'b01, ac};
            obs_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ImmSrc, RegSrc, ALUControl};
            n_cmp++;
            if (State !== STATE_W'(seq[i])) begin
                n_fail++;
                $display("FAIL %s state[%0d]: got %0d want %0d", tag, i, State, seq[i]);
            end
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s ctrl[%0d] (pcw,adr,mw,irw,rw,rs,sa,sb,imm,rsrc,alu): got %b want %b",
                         tag, i, obs_v, exp_v);
            end
            ncyc++;
            if (RegWrite === 1'b1) nregw++;
            if (MemWrite === 1'b1) nmemw++;
            if (State === STATE_W'(S_MEMREAD)) nmemrd++;
            last_pcw = PCWrite;
            if ((seq[i] == S_EXECUTER || seq[i] == S_EXECUTEI) && ce) begin
                arith = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);
                known = arith || (funct[4:1] == 4'b0000) || (funct[4:1] == 4'b1100);
                if (is_cmp_model(funct)) begin
                    mdl_flags = al;
                end else if (known && funct[0]) begin
                    mdl_flags[3:2] = al[3:2];
                    if (arith) mdl_flags[1:0] = al[1:0];
                end
            end
            @(posedge CLK); #1;
        end
        $display("instr %s: cond=%h op=%b funct=%b rd=%0d cycles=%0d flags=%b",
                 tag, cond, op, funct, rd, ncyc, mdl_flags);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; ALUFlags = 4'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        n_cmp++;
        if (State !== STATE_W'(S_FETCH)) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", State, S_FETCH);
        end
        n_cmp++;
        if ({IRWrite, PCWrite, RegWrite, MemWrite} !== 4'b1100) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 1100", {IRWrite, PCWrite, RegWrite, MemWrite});
        end
        @(posedge CLK); #1;
        Reset = 1'b0;
        mdl_flags = 4'b0000;
        $display("transaction reset: state=%0d", State);
    endtask

    task automatic test_add();
        int c, rw, mw, mr; logic p;
        run_instr("ADD", 4'hE, 2'b00, 6'b001000, 4'd1, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (c !== 4 || rw !== 1) begin
            n_fail++; $display("FAIL add_seq: got cycles=%0d regw=%0d want cycles=4 regw=1", c, rw);
        end
    endtask

    task automatic test_ldr();
        int c, rw, mw, mr; logic p;
        run_instr("LDR", 4'hE, 2'b01, 6'b011001, 4'd2, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (c !== 3 + MEM_LAT + 1 || mr !== MEM_LAT || rw !== 1) begin
            n_fail++;
            $display("FAIL ldr_seq: got cycles=%0d memread=%0d regw=%0d want cycles=%0d memread=%0d regw=1",
                     c, mr, rw, 3 + MEM_LAT + 1, MEM_LAT);
        end
    endtask

    task automatic test_subs_beq();
        int c, rw, mw, mr; logic p;
        run_instr("SUBS_z1", 4'hE, 2'b00, 6'b000101, 4'd3, 1'b1, 4'b0100, c, rw, mw, mr, p);
        run_instr("BEQ_taken", 4'h0, 2'b10, 6'b100000, 4'd0, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (p !== 1'b1 || c !== 3) begin
            n_fail++; $display("FAIL beq_taken: got pcw=%b cycles=%0d want pcw=1 cycles=3", p, c);
        end
        run_instr("SUBS_z0", 4'hE, 2'b00, 6'b000101, 4'd3, 1'b1, 4'b0000, c, rw, mw, mr, p);
        run_instr("BEQ_not", 4'h0, 2'b10, 6'b100000, 4'd0, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (p !== 1'b0) begin
            n_fail++; $display("FAIL beq_not_taken: got pcw=%b want 0", p);
        end
    endtask

    task automatic test_str_cond_fail();
        int c, rw, mw, mr; logic p;
        run_instr("STR_fail", 4'h0, 2'b01, 6'b011000, 4'd4, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (c !== 4 || mw !== 0) begin
            n_fail++; $display("FAIL str_fail: got cycles=%0d memw=%0d want cycles=4 memw=0", c, mw);
        end
        run_instr("BNE", 4'h1, 2'b10, 6'b100000, 4'd0, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (p !== 1'b1) begin
            n_fail++; $display("FAIL str_flags_kept: got pcw=%b want 1", p);
        end
        run_instr("STR_al", 4'hE, 2'b01, 6'b011000, 4'd4, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (mw !== 1) begin
            n_fail++; $display("FAIL str_al: got memw=%0d want 1", mw);
        end
    endtask

    task automatic test_cmp();
        int c, rw, mw, mr; logic p;
        logic exp_beq;
        run_instr("SUBS_clr", 4'hE, 2'b00, 6'b000101, 4'd5, 1'b1, 4'b0000, c, rw, mw, mr, p);
        run_instr("CMP", 4'hE, 2'b00, 6'b010101, 4'd6, 1'b1, 4'b0100, c, rw, mw, mr, p);
`ifdef CU_CMP_EN
        n_cmp++;
        if (c !== 3 || rw !== 0) begin
            n_fail++; $display("FAIL cmp_seq: got cycles=%0d regw=%0d want cycles=3 regw=0", c, rw);
        end
        exp_beq = 1'b1;
`else
        n_cmp++;
        if (c !== 4 || rw !== 1) begin
            n_fail++; $display("FAIL cmp_unknown: got cycles=%0d regw=%0d want cycles=4 regw=1", c, rw);
        end
        exp_beq = 1'b0;
`endif
        run_instr("BEQ_cmp", 4'h0, 2'b10, 6'b100000, 4'd0, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (p !== exp_beq) begin
            n_fail++; $display("FAIL cmp_flags: got pcw=%b want %b", p, exp_beq);
        end
    endtask

    task automatic test_reset_mid();
        int c, rw, mw, mr; logic p;
        run_instr("SUBS_set", 4'hE, 2'b00, 6'b000101, 4'd7, 1'b1, 4'b1111, c, rw, mw, mr, p);
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd8;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        n_cmp++;
        if (State !== STATE_W'(S_MEMREAD)) begin
            n_fail++; $display("FAIL mid_reach_memread: got %0d want %0d", State, S_MEMREAD);
        end
        Reset = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        n_cmp++;
        if (State !== STATE_W'(S_FETCH) || IRWrite !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: got state=%0d irw=%b want state=%0d irw=1", State, IRWrite, S_FETCH);
        end
        @(posedge CLK); #1;
        Reset = 1'b0;
        mdl_flags = 4'b0000;
        $display("transaction mid_reset: state=%0d", State);
        run_instr("BEQ_after", 4'h0, 2'b10, 6'b100000, 4'd0, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (p !== 1'b0) begin
            n_fail++; $display("FAIL mid_flags_z: got pcw=%b want 0", p);
        end
        run_instr("BPL_after", 4'h5, 2'b10, 6'b100000, 4'd0, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (p !== 1'b1) begin
            n_fail++; $display("FAIL mid_flags_n: got pcw=%b want 1", p);
        end
        run_instr("LDR_after", 4'hE, 2'b01, 6'b011001, 4'd9, 1'b0, 4'b0, c, rw, mw, mr, p);
        n_cmp++;
        if (mr !== MEM_LAT) begin
            n_fail++; $display("FAIL mid_counter: got memread=%0d want %0d", mr, MEM_LAT);
        end
    endtask

    task automatic test_random();
        int c, rw, mw, mr; logic p;
        logic [3:0] cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        logic [3:0] cond, rd;
        logic [1:0] op;
        logic [5:0] funct;
        for (int n = 0; n < 150; n++) begin
            cond  = 4'($urandom);
            op    = 2'($urandom);
            funct = 6'($urandom);
            if ($urandom_range(0, 1) == 1) funct[4:1] = cmds[$urandom_range(0, 4)];
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr("RAND", cond, op, funct, rd, 1'b0, 4'b0, c, rw, mw, mr, p);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr();
        test_subs_beq();
        test_str_cond_fail();
        test_cmp();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
